// File: rtl/spi_master_fe_pkg.sv
// rtl/spi_master_fe_pkg.sv - shared SPI word width and sclk timing defaults
// Master and slave benches import these so both sides agree on framing.
package spi_master_fe_pkg;

  localparam int SPI_DATA_W_DEFAULT   = 8;
  localparam int SPI_HALF_PER_DEFAULT = 8;

endpackage

// File: rtl/spi_master_fe.sv
// rtl/spi_master_fe.sv - mode 0, MSB-first SPI master, one word per ss assertion
// miso is captured on the cycle sclk is driven high, giving the slave HALF_PER cycles after each fall.
module spi_master_fe
  import spi_master_fe_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W_DEFAULT,
  parameter int HALF_PER = SPI_HALF_PER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = $clog2(HALF_PER);
  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                sclk_q, sclk_d;
  logic                ss_q, ss_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_end;

  assign phase_end = (cnt_q == CNT_W'(HALF_PER - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_d    = data_in;
          rx_d    = '0;
          bit_d   = '0;
          cnt_d   = '0;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], miso};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          sclk_d  = 1'b0;
          tx_d    = {tx_q[DATA_W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BIT_W'(DATA_W - 1)) ? S_HOLD : S_LOW;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          ss_d    = 1'b1;
          dout_d  = rx_q;
          done_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_end) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_q has fully shifted out to zero by HOLD, so mosi idles low without extra gating.
  assign mosi     = tx_q[DATA_W-1];
  assign sclk     = sclk_q;
  assign ss       = ss_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master_fe.sv
// tb/tb_spi_master_fe.sv - scoreboard bench for spi_master_fe (8-bit and 32-bit instances)
module tb_spi_master_fe;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start32;
  logic [7:0]  din8, dout8;
  logic [31:0] din32, dout32;
  logic        busy8, done8, sclk8, ss8, mosi8, miso8;
  logic        busy32, done32, sclk32, ss32, mosi32, miso32;
  logic        lb;
  logic        miso8_s = 1'b0, miso32_s = 1'b0;

  always #5 clk = ~clk;

  assign miso8  = lb ? mosi8 : miso8_s;
  assign miso32 = miso32_s;

  spi_master_fe #(.DATA_W(8), .HALF_PER(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(din8), .data_out(dout8),
    .busy(busy8), .done(done8), .sclk(sclk8), .ss(ss8), .mosi(mosi8), .miso(miso8));

  spi_master_fe #(.DATA_W(32), .HALF_PER(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .data_in(din32), .data_out(dout32),
    .busy(busy32), .done(done32), .sclk(sclk32), .ss(ss32), .mosi(mosi32), .miso(miso32));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: stimulus pushes expected words, monitor pops on each done pulse.
  logic [7:0]  exp8_q[$];
  logic [31:0] exp32_q[$];

  always @(negedge clk) begin
    if (done8) begin
      if (exp8_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dout8_unexpected_done: got %0h, expected no done (cycle %0d)", dout8, cyc);
      end else check("dout8", {24'h0, dout8}, {24'h0, exp8_q.pop_front()});
    end
    if (done32) begin
      if (exp32_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dout32_unexpected_done: got %0h, expected no done (cycle %0d)", dout32, cyc);
      end else check("dout32", dout32, exp32_q.pop_front());
    end
  end

  // Slave models: load on ss fall, update miso a fixed number of cycles after each sclk fall.
  logic [7:0]  s8_tx, s8_rx = 8'h0, s8_word = 8'h0;
  logic [31:0] s32_tx;
  logic        s8_sp = 1'b0, s8_ssp = 1'b1, s32_sp = 1'b0, s32_ssp = 1'b1;
  int          s8_pend = 0, s8_dly = 1, s32_pend = 0;

  always @(negedge clk) begin
    if (!ss8 && s8_ssp) begin
      s8_tx = s8_word; s8_rx = 8'h0; miso8_s = s8_tx[7]; s8_pend = 0;
    end
    if (s8_pend > 0) begin
      s8_pend--;
      if (s8_pend == 0) begin s8_tx = {s8_tx[6:0], 1'b0}; miso8_s = s8_tx[7]; end
    end
    if (sclk8 && !s8_sp) s8_rx = {s8_rx[6:0], mosi8};
    if (!sclk8 && s8_sp) s8_pend = s8_dly;
    s8_sp = sclk8; s8_ssp = ss8;

    if (!ss32 && s32_ssp) begin
      s32_tx = 32'hDEADBEEF; miso32_s = s32_tx[31]; s32_pend = 0;
    end
    if (s32_pend > 0) begin
      s32_pend--;
      if (s32_pend == 0) begin s32_tx = {s32_tx[30:0], 1'b0}; miso32_s = s32_tx[31]; end
    end
    if (!sclk32 && s32_sp) s32_pend = 3;
    s32_sp = sclk32; s32_ssp = ss32;
  end

  task automatic start_xfer8(input logic [7:0] d, output int t0);
    @(negedge clk);
    start8 = 1'b1; din8 = d; t0 = cyc;
    @(negedge clk);
    start8 = 1'b0; din8 = ~d;
  endtask

  task automatic wait_idle8(input string name, input int bound);
    int k = 0;
    while (busy8 && k < bound) begin @(negedge clk); k++; end
    if (busy8) check(name, {31'h0, busy8}, 32'h0);
  endtask

  int t0, rel, rises, ndone, done_cyc, busy_low, nfall, hi_cnt, gap;
  logic [7:0] bits;
  logic p, ssp;

  initial begin
    rst = 1'b1; start8 = 1'b0; start32 = 1'b0; din8 = 8'h0; din32 = 32'h0; lb = 1'b1;
    repeat (3) @(negedge clk);
    check("reset8_pins", {27'h0, sclk8, ss8, mosi8, busy8, done8}, 32'h08);
    check("reset8_dout", {24'h0, dout8}, 32'h0);
    check("reset32_pins", {27'h0, sclk32, ss32, mosi32, busy32, done32}, 32'h08);
    check("reset32_dout", dout32, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Loopback 0xA5: timing of rises, done and busy release.
    lb = 1'b1;
    exp8_q.push_back(8'hA5);
    start_xfer8(8'hA5, t0);
    check("cycle1_ss_busy_mosi", {29'h0, ss8, busy8, mosi8}, 32'h3);
    p = sclk8; rises = 0; bits = 8'h0; ndone = 0; done_cyc = -1; busy_low = -1;
    for (int i = 0; i < 120 && busy_low < 0; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (sclk8 && !p) begin
        if (rises == 0) check("first_rise_cycle", rel, 5);
        rises++; bits = {bits[6:0], mosi8};
      end
      p = sclk8;
      if (done8) begin ndone++; done_cyc = rel; check("ss_high_at_done", {31'h0, ss8}, 32'h1); end
      if (!busy8) busy_low = rel;
    end
    check("rise_count", rises, 8);
    check("mosi_bits", {24'h0, bits}, 32'hA5);
    check("done_cycle", done_cyc, 69);
    check("done_count", ndone, 1);
    check("busy_low_cycle", busy_low, 73);

    // Slave returns 0x3C while master sends 0xC3; a start during busy must be ignored.
    lb = 1'b0; s8_word = 8'h3C; s8_dly = 1;
    exp8_q.push_back(8'h3C);
    start_xfer8(8'hC3, t0);
    ndone = 0; busy_low = -1;
    for (int i = 0; i < 120 && busy_low < 0; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == 20) begin start8 = 1'b1; din8 = 8'hFF; end
      if (rel == 21) start8 = 1'b0;
      if (done8) ndone++;
      if (!busy8) busy_low = rel;
    end
    check("slave_rx", {24'h0, s8_rx}, 32'hC3);
    check("busy_start_ignored_done_count", ndone, 1);
    repeat (2) @(negedge clk);
    check("no_queued_start", {31'h0, busy8}, 32'h0);

    // start held high: two back-to-back words, ss high gap of HALF_PER+1.
    lb = 1'b1;
    exp8_q.push_back(8'h5A);
    exp8_q.push_back(8'h5A);
    @(negedge clk);
    start8 = 1'b1; din8 = 8'h5A;
    ssp = 1'b1; nfall = 0; hi_cnt = 0; gap = -1;
    for (int i = 0; i < 400 && !(nfall == 2 && !busy8); i++) begin
      @(negedge clk);
      if (!ss8 && ssp) begin
        if (nfall == 1) gap = hi_cnt;
        nfall++;
        if (nfall == 2) start8 = 1'b0;
      end
      hi_cnt = ss8 ? hi_cnt + 1 : 0;
      ssp = ss8;
    end
    start8 = 1'b0;
    check("b2b_word_count", nfall, 2);
    check("b2b_ss_gap", gap, 5);

    // Reset at cycle 30 aborts; then a fresh transfer completes.
    start_xfer8(8'h96, t0);
    while (cyc - t0 < 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pins", {27'h0, sclk8, ss8, mosi8, busy8, done8}, 32'h08);
    check("abort_dout", {24'h0, dout8}, 32'h0);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    exp8_q.push_back(8'h3E);
    start_xfer8(8'h3E, t0);
    wait_idle8("post_abort_busy_timeout", 120);

    // 32-bit word against a slave updating miso 3 cycles after each fall.
    exp32_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    start32 = 1'b1; din32 = 32'h12345678;
    @(negedge clk);
    start32 = 1'b0; din32 = 32'h0;
    for (int i = 0; i < 400 && busy32; i++) @(negedge clk);
    check("busy32_done", {31'h0, busy32}, 32'h0);

    repeat (3) @(negedge clk);
    check("sb8_empty", exp8_q.size(), 0);
    check("sb32_empty", exp32_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
